// File: rtl/dac_pkg.sv
// Shared constants and types for the unit-element DAC sequencer.
package dac_pkg;

  localparam int DAC_CODE_W = 4;
  localparam int DAC_ELEM   = 15;

  typedef logic [DAC_CODE_W-1:0] code_t;
  typedef logic [DAC_ELEM-1:0]   elem_t;

  // Element rotation pointer, always kept in 0..DAC_ELEM-1.
  typedef logic [3:0] ptr_t;

endpackage

// File: rtl/dac_sequencer_if.sv
// Upstream sample stream into the DAC sequencer.
interface dac_sequencer_if;
  import dac_pkg::*;

  // Handshake: a sample transfers on a rising clk edge where s_valid and
  // s_ready are both high; the master holds s_valid and s_data stable until
  // that edge, and s_ready never depends on s_valid.
  logic  s_valid;
  code_t s_data;
  logic  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/dac_thermometer.sv
// Binary code to thermometer decoder: code N lights elements 0..N-1.
module dac_thermometer
  import dac_pkg::*;
(
  input  code_t code,
  output elem_t therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < DAC_ELEM; i++) begin
      therm[i] = (code > code_t'(i));
    end
  end

endmodule

// File: rtl/dac_sequencer.sv
// Buffers binary DAC codes and, on each sample-rate tick, drives a rotated
// (data-weighted-averaging) thermometer pattern onto the unit elements.
module dac_sequencer
  import dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             dwa_en,
  dac_sequencer_if.slave   s,
  output elem_t            elem,
  output logic             sample_strobe,
  output logic             underflow,
  input  logic             clr_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  code_t            mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  ptr_t             p;
  ptr_t             rot;
  ptr_t             p_next;
  logic [4:0]       p_sum;
  code_t            code;
  elem_t            therm;
  elem_t            rotated;

  // Full/empty come from registered occupancy, so a same-cycle pop never
  // frees a slot for a push and a same-cycle push never feeds a tick.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign s.s_ready = !full;
  assign push      = s.s_valid && !full;
  assign tick      = en && (tick_cnt >= div);
  assign pop       = tick && !empty;
  assign code      = mem[rd_ptr];

  dac_thermometer u_therm (
    .code  (code),
    .therm (therm)
  );

  // Cyclic left rotation within the element array; rot==0 shifts the wrap
  // term out completely.
  assign rot     = dwa_en ? p : '0;
  assign rotated = (therm << rot) | (therm >> (4'(DAC_ELEM) - rot));

  assign p_sum  = {1'b0, p} + {1'b0, code};
  assign p_next = (p_sum >= 5'd15) ? ptr_t'(p_sum - 5'd15) : p_sum[3:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A div lowered below the running count ticks on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (!dwa_en) begin
      p <= '0;
    end else if (pop) begin
      p <= p_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem          <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= pop;
      if (pop) begin
        elem <= rotated;
      end
    end
  end

  // Setting wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (tick && empty) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sequencer.sv
// Self-checking bench for dac_sequencer: directed scenarios plus random traffic.
module tb_dac_sequencer;
  import dac_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] div = '0;
  logic          dwa_en = 1'b0;
  logic          clr_underflow = 1'b0;
  elem_t         elem;
  logic          sample_strobe;
  logic          underflow;

  dac_sequencer_if sif ();

  dac_sequencer #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .div           (div),
    .dwa_en        (dwa_en),
    .s             (sif),
    .elem          (elem),
    .sample_strobe (sample_strobe),
    .underflow     (underflow),
    .clr_underflow (clr_underflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          m_q[$];
  int          src_q[$];
  logic [14:0] exp_q[$];
  logic [14:0] dir_q[$];
  int          m_cnt;
  int          m_p;
  logic [14:0] m_elem;
  logic        m_strobe;
  logic        m_uf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Thermometer of n units rotated left by rot inside 15 elements.
  function automatic logic [14:0] expect_elem(input int n, input int rot);
    int t;
    int r;
    t = (1 << n) - 1;
    r = ((t << rot) | (t >> (15 - rot))) & 32'h7fff;
    return r[14:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_cnt    = 0;
    m_p      = 0;
    m_elem   = '0;
    m_strobe = 1'b0;
    m_uf     = 1'b0;
  endtask

  task automatic check_outputs();
    logic [14:0] e;
    check_eq("elem", 32'(elem), 32'(m_elem));
    check_eq("strobe", 32'(sample_strobe), 32'(m_strobe));
    check_eq("underflow", 32'(underflow), 32'(m_uf));
    check_eq("s_ready", 32'(sif.s_ready), 32'(m_q.size() < DEPTH));
    if (sample_strobe) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_strobe", 32'(sample_strobe), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_elem", 32'(elem), 32'(e));
        if (dir_q.size() != 0) check_eq("dir_elem", 32'(elem), 32'(dir_q.pop_front()));
      end
    end
  endtask

  // clr_mode: 0 never, 1 on tick cycles, 2 on non-tick cycles, 3 always, 4 random
  task automatic step(input logic en_i, input int div_i, input logic dwa_i, input int clr_mode);
    logic tick;
    logic clr_i;
    logic accept;
    logic uf_set;
    int   n;
    int   rot;
    tick = en_i && (m_cnt >= div_i);
    case (clr_mode)
      1:       clr_i = tick;
      2:       clr_i = !tick;
      3:       clr_i = 1'b1;
      4:       clr_i = ($urandom_range(0, 15) == 0);
      default: clr_i = 1'b0;
    endcase
    en            = en_i;
    div           = DW'(div_i);
    dwa_en        = dwa_i;
    clr_underflow = clr_i;
    sif.s_valid   = (src_q.size() != 0);
    sif.s_data    = (src_q.size() != 0) ? 4'(src_q[0]) : 4'($urandom_range(0, 15));
    accept        = sif.s_valid && (m_q.size() < DEPTH);
    uf_set        = 1'b0;
    m_strobe      = 1'b0;
    if (tick) begin
      if (m_q.size() != 0) begin
        n        = m_q.pop_front();
        rot      = dwa_i ? m_p : 0;
        m_elem   = expect_elem(n, rot);
        if (dwa_i) m_p = (m_p + n) % 15;
        m_strobe = 1'b1;
        exp_q.push_back(m_elem);
      end else begin
        m_uf   = 1'b1;
        uf_set = 1'b1;
      end
    end
    if (clr_i && !uf_set) m_uf = 1'b0;
    if (!dwa_i) m_p = 0;
    m_cnt = (!en_i || tick) ? 0 : m_cnt + 1;
    if (accept) m_q.push_back(src_q.pop_front());
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int cycles, input logic en_i, input int div_i, input logic dwa_i,
                     input int clr_mode);
    for (int i = 0; i < cycles; i++) step(en_i, div_i, dwa_i, clr_mode);
  endtask

  task automatic do_reset();
    en            = 1'b0;
    dwa_en        = 1'b0;
    div           = '0;
    clr_underflow = 1'b0;
    sif.s_valid   = 1'b0;
    sif.s_data    = '0;
    #2;
    rst = 1'b1;
    model_reset();
    src_q.delete();
    dir_q.delete();
    #1;
    check_eq("rst_elem", 32'(elem), 32'd0);
    check_eq("rst_strobe", 32'(sample_strobe), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_ready", 32'(sif.s_ready), 32'd1);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic r_en;
    logic r_dwa;
    int   r_div;

    do_reset();

    // Single sample at div=3 without rotation, then empty ticks.
    src_q = '{5};
    dir_q = '{15'h001F};
    run(16, 1'b1, 3, 1'b0, 0);
    check_eq("r029_uf", 32'(underflow), 32'd1);
    check_eq("r029_hold", 32'(elem), 32'h001F);

    // Rotation sequence; the trailing code 1 exposes the final pointer (7).
    do_reset();
    src_q = '{3, 4, 15, 0, 1};
    dir_q = '{15'h0007, 15'h0078, 15'h7FFF, 15'h0000, 15'h0080};
    run(14, 1'b1, 1, 1'b1, 0);
    check_eq("r030_dir_done", 32'(dir_q.size()), 32'd0);

    // Pointer wrap past element 14; trailing code 1 shows pointer 2.
    do_reset();
    src_q = '{14, 3, 1};
    dir_q = '{15'h3FFF, 15'h4003, 15'h0004};
    run(10, 1'b1, 1, 1'b1, 0);
    check_eq("r031_dir_done", 32'(dir_q.size()), 32'd0);

    // Fill the buffer with the timebase off, then drain in order.
    do_reset();
    src_q = '{1, 2, 6, 9, 12};
    dir_q = '{15'h0001, 15'h0003, 15'h003F, 15'h01FF, 15'h0FFF};
    run(6, 1'b0, 0, 1'b0, 0);
    check_eq("r032_full_ready", 32'(sif.s_ready), 32'd0);
    run(8, 1'b1, 0, 1'b0, 0);
    check_eq("r032_dir_done", 32'(dir_q.size()), 32'd0);

    // Clear coinciding with an underflow tick, then a clear alone.
    do_reset();
    run(4, 1'b1, 1, 1'b0, 1);
    check_eq("r033_uf_coincide", 32'(underflow), 32'd1);
    run(2, 1'b0, 1, 1'b0, 3);
    check_eq("r033_uf_cleared", 32'(underflow), 32'd0);

    // Push with concurrent empty tick underflows; then reset with 3 buffered.
    do_reset();
    src_q = '{9};
    run(3, 1'b1, 0, 1'b0, 0);
    check_eq("r020_uf", 32'(underflow), 32'd1);
    check_eq("r020_elem", 32'(elem), 32'h01FF);
    src_q = '{1, 2, 3};
    run(5, 1'b0, 0, 1'b0, 0);
    do_reset();
    run(1, 1'b1, 0, 1'b0, 0);
    check_eq("r034_post_uf", 32'(underflow), 32'd1);
    check_eq("r034_post_elem", 32'(elem), 32'd0);

    // Random traffic with varying rate, rotation and clears.
    do_reset();
    r_en  = 1'b1;
    r_dwa = 1'b1;
    r_div = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) r_div = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) r_dwa = !r_dwa;
      r_en = ($urandom_range(0, 15) != 0);
      if (src_q.size() == 0 && $urandom_range(0, 2) != 0) src_q.push_back($urandom_range(0, 15));
      step(r_en, r_div, r_dwa, 4);
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_sequencer.md
DAC_SEQUENCER -- requirements
Module: dac_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of the sample-period divider.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, sample-rate timebase enable.
REQ-006 SHALL have port div, input, DIV_W, sample period minus one, in clk cycles.
REQ-007 SHALL have port dwa_en, input, 1, data-weighted-averaging element rotation enable.
REQ-008 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-009 SHALL have port s_data, input, 4, upstream binary DAC code 0..15.
REQ-010 SHALL have port s_ready, output, 1, sample accepted when s_valid and s_ready are both high at a clk edge.
REQ-011 SHALL have port elem, output, 15, registered unit-element enables to the DAC array.
REQ-012 SHALL have port sample_strobe, output, 1, one-cycle pulse marking a new elem value.
REQ-013 SHALL have port underflow, output, 1, sticky flag: sample tick with empty buffer.
REQ-014 SHALL have port clr_underflow, input, 1, clears underflow.

Function
REQ-015 SHALL implement s_ready = not full; no push when full, even if a pop occurs in the same cycle.
REQ-016 SHALL keep an occupancy count 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL keep a tick counter: en=0 forces it to 0 with no ticks; en=1 and counter>=div produces a tick and loads 0; otherwise it increments. A mid-count decrease of div below the counter value ticks on the next cycle.
REQ-018 SHALL, on a tick with buffer non-empty: pop code N, load elem with the 15-bit thermometer code of N rotated left by pointer P (cyclic within 15 bits), set P <= (P+N) mod 15, and pulse sample_strobe on the cycle elem is first valid.
REQ-019 SHALL, on a tick with buffer empty: hold elem and P, set underflow, no strobe.
REQ-020 SHALL evaluate empty before same-cycle pushes (no bypass); an empty buffer with a concurrent push and tick is an underflow.
REQ-021 SHALL hold P at 0 while dwa_en=0; dwa_en changes apply to the next tick.
REQ-022 SHALL satisfy: N=0 gives elem=0 and P unchanged; N=15 gives elem=all ones and P unchanged.
REQ-023 SHALL give set priority over clear when an underflow and clr_underflow coincide.
REQ-024 SHALL require minimum latency from accept edge to elem update of 1 cycle, i.e. the next tick edge.

Reset
REQ-025 SHALL, on rst, asynchronously clear the buffer (s_ready=1), the tick counter, P, elem (0), sample_strobe (0), and underflow (0).
REQ-026 SHALL discard buffered samples on reset mid-operation; the first post-reset tick then underflows unless a sample is pushed beforehand.

Structure
REQ-027 SHALL place DAC_CODE_W=4, DAC_ELEM=15, and a pointer typedef (4-bit, range 0..14) in shared package dac_pkg.
REQ-028 SHALL instantiate the existing dac_thermometer decoder as the single sub-module; rotation and sequencing stay in this module.

Verification
REQ-029 SHALL cover: div=3, en=1, dwa_en=0, push 5 -> strobe every 4 cycles; first tick elem=0x001F, later ticks underflow=1 with elem held.
REQ-030 SHALL cover: dwa_en=1, push 3,4,15,0 -> elem=0x0007, 0x0078, 0x7FFF, 0x0000; P=3, 7, 7, 7.
REQ-031 SHALL cover wrap: dwa_en=1, push 14,3 -> elem=0x3FFF (P=14), then 0x4003 (P=2).
REQ-032 SHALL cover: en=0, push FIFO_DEPTH+1 samples -> s_ready low after 4 accepts, fifth held off; en=1 drains in order.
REQ-033 SHALL cover: clr_underflow coinciding with an underflow tick -> underflow remains 1; a later clear alone -> 0.
REQ-034 SHALL cover: assert rst mid-stream with 3 buffered -> all outputs 0 immediately, s_ready=1, first tick underflows.
